// File: rtl/inst_sram_responder_if.sv
// rtl/inst_sram_responder_if.sv - fetch AR/R handshake and backing-store port bundle
//
// Purpose : groups the IFU fetch handshake (AR + R) and the backing-store read
//           port of the instruction SRAM responder into one bundle.
// Ports   : arvalid/araddr/arready  read address channel
//           rvalid/rdata/rresp/rready read data channel
//           mem_en/mem_addr/mem_rdata backing-store read port
// Modports: slave  - the responder (accepts AR, drives R, drives the memory strobe)
//           master - the IFU/testbench side (drives AR, accepts R, supplies mem_rdata)

interface inst_sram_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rready;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  arvalid, araddr, rready, mem_rdata,
        output arready, rvalid, rdata, rresp, mem_en, mem_addr
    );

    modport master (
        output arvalid, araddr, rready, mem_rdata,
        input  arready, rvalid, rdata, rresp, mem_en, mem_addr
    );
endinterface

// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - read-only instruction memory responder for IFU fetches
//
// Purpose : accepts one fetch address at a time, waits a programmable latency,
//           reads the backing store and returns the word with a response code
//           (00 OKAY, 10 SLVERR misaligned, 11 DECERR out of range).
// Ports   : clk       clock
//           rst       synchronous active-high reset
//           bus       inst_sram_responder_if.slave (AR/R handshake + memory port)
// Options : ISRAM_RAND_DELAY_EN - when defined, adds 0..7 pseudo-random wait
//           cycles per transaction from an 8-bit LFSR; when undefined the
//           latency is exactly LATENCY and no LFSR exists.

module inst_sram_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LATENCY    = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] MEM_BYTES  = 32'h0800_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    inst_sram_responder_if.slave      bus
);

    localparam int CNT_W = 9;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Range bounds carry one extra bit so BASE_ADDR+MEM_BYTES wrapping past
    // the top of the address space cannot alias onto low addresses.
    localparam logic [ADDR_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] RANGE_HI = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES}
                                               - (ADDR_WIDTH+1)'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    mem_en;
    logic [CNT_W-1:0]        extra_wait;
    logic [CNT_W-1:0]        cnt_load;
    logic                    misaligned;
    logic                    out_of_range;
    logic [ADDR_WIDTH:0]     addr_ext;

`ifdef ISRAM_RAND_DELAY_EN
    // x^8+x^6+x^5+x^4+1, shifted left; stepped once per accepted address.
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign extra_wait = {{(CNT_W-3){1'b0}}, lfsr_q[2:0]};

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_IDLE && bus.arvalid && arready_q) begin
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign extra_wait = '0;
`endif

    // cnt counts the remaining idle WAIT cycles; the fetch happens on the
    // WAIT cycle where it reads zero, so LATENCY=1 loads zero.
    assign cnt_load = CNT_W'(LATENCY - 1) + extra_wait;

    assign addr_ext     = {1'b0, addr_q};
    assign misaligned   = (addr_q[1:0] != 2'b00);
    assign out_of_range = (addr_ext < RANGE_LO) || (addr_ext > RANGE_HI);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        mem_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.arvalid && arready_q) begin
                    addr_d  = bus.araddr;
                    cnt_d   = cnt_load;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                    // Misalignment is reported ahead of the range check.
                    if (misaligned) begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = '0;
                    end else if (out_of_range) begin
                        rresp_d = RESP_DECERR;
                        rdata_d = '0;
                    end else begin
                        mem_en  = 1'b1;
                        rresp_d = RESP_OKAY;
                        rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rready) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                rvalid_d = 1'b0;
            end
        endcase

        // Registered ready: high exactly while the next state is IDLE.
        arready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bus.arready  = arready_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.rresp    = rresp_q;
    assign bus.mem_en   = mem_en;
    // Address is parked at zero when no read is strobed.
    assign bus.mem_addr = mem_en ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;

endmodule
